// File: rtl/tlb_maint_pkg.sv
// Shared definitions for the TLB maintenance sequencer: op codes, FSM state
// encoding and default sizing.
package tlb_maint_pkg;

  localparam int TLBNUM_DEF = 16;
  localparam int IDX_W_DEF  = 4;

  localparam logic [1:0] TLBOP_P      = 2'd0;
  localparam logic [1:0] TLBOP_R      = 2'd1;
  localparam logic [1:0] TLBOP_WI     = 2'd2;
  localparam logic [1:0] TLBOP_INVALL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PROBE   = 3'd1,
    ST_READ    = 3'd2,
    ST_WRITE   = 3'd3,
    ST_SWEEP   = 3'd4,
    ST_REFETCH = 3'd5,
    ST_DONE    = 3'd6
  } tlb_maint_state_e;

endpackage

// File: rtl/tlb_maint_ctrl_if.sv
// Command handshake and TLB port bundle between pipeline, maintenance
// sequencer and TLB array. The controller uses the slave modport.
interface tlb_maint_ctrl_if
  import tlb_maint_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
);

  logic             op_valid;
  logic [1:0]       op_code;
  logic [IDX_W-1:0] op_index;
  logic             op_ready;
  logic             op_done;
  logic             flush;
  logic             busy;

  logic             s1_req;
  logic             s1_found;
  logic [IDX_W-1:0] s1_index;
  logic             probe_found;
  logic [IDX_W-1:0] probe_index;

  logic             we;
  logic [IDX_W-1:0] w_index;
  logic             w_clear;
  logic [IDX_W-1:0] r_index;
  logic             r_latch;
  logic             refetch_req;

  modport slave (
    input  op_valid, op_code, op_index, flush, s1_found, s1_index,
    output op_ready, op_done, busy, s1_req, probe_found, probe_index,
           we, w_index, w_clear, r_index, r_latch, refetch_req
  );

  modport master (
    output op_valid, op_code, op_index, flush, s1_found, s1_index,
    input  op_ready, op_done, busy, s1_req, probe_found, probe_index,
           we, w_index, w_clear, r_index, r_latch, refetch_req
  );

endinterface

// File: rtl/tlb_sweep_cnt.sv
// Entry counter for the INVALL sweep: counts 0..TLBNUM-1 while enabled and
// flags the final entry so the sequencer can leave the sweep.
module tlb_sweep_cnt
  import tlb_maint_pkg::*;
#(
  parameter int TLBNUM = TLBNUM_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [IDX_W-1:0] cnt_o,
  output logic             last_o
);

  logic [IDX_W-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == IDX_W'(TLBNUM - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_o ? '0 : cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: runs TLBP/TLBR/TLBWI/INVALL one at a time onto the
// TLB ports. Define TLB_MAINT_SWEEP_EN to build the INVALL sweep; otherwise INVALL is a no-op.
//
// state   | meaning
// IDLE    | ready for a command
// PROBE   | owns search port 1, captures hit result
// READ    | read port at idx_q, CP0 latches data
// WRITE   | write port at idx_q
// SWEEP   | clears entry cnt each cycle (INVALL)
// REFETCH | refetch pulse plus completion
// DONE    | completion without refetch
module tlb_maint_ctrl
  import tlb_maint_pkg::*;
#(
  parameter int TLBNUM = TLBNUM_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input logic             clk,
  input logic             resetn,
  tlb_maint_ctrl_if.slave bus
);

  if (IDX_W != $clog2(TLBNUM)) begin : g_bad_idx_w
    $error("tlb_maint_ctrl: IDX_W must equal clog2(TLBNUM)");
  end

  tlb_maint_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             probe_found_q, probe_found_d;
  logic [IDX_W-1:0] probe_index_q, probe_index_d;

  logic             op_ready;
  logic             op_done;
  logic             s1_req;
  logic             we;
  logic             w_clear;
  logic [IDX_W-1:0] w_index;
  logic             r_latch;
  logic             refetch_req;
  logic             accept;

`ifdef TLB_MAINT_SWEEP_EN
  logic [IDX_W-1:0] cnt;
  logic             cnt_last;

  tlb_sweep_cnt #(
    .TLBNUM (TLBNUM),
    .IDX_W  (IDX_W)
  ) u_sweep_cnt (
    .clk    (clk),
    .resetn (resetn),
    .en_i   (state_q == ST_SWEEP),
    .clr_i  (state_q == ST_IDLE),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );
`endif

  // A flush in IDLE must not let a command slip in behind the redirect.
  assign op_ready = (state_q == ST_IDLE) && !bus.flush;
  assign accept   = bus.op_valid && op_ready;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    probe_found_d = probe_found_q;
    probe_index_d = probe_index_q;
    op_done       = 1'b0;
    s1_req        = 1'b0;
    we            = 1'b0;
    w_clear       = 1'b0;
    w_index       = idx_q;
    r_latch       = 1'b0;
    refetch_req   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          idx_d = bus.op_index;
          case (bus.op_code)
            TLBOP_P:  state_d = ST_PROBE;
            TLBOP_R:  state_d = ST_READ;
            TLBOP_WI: state_d = ST_WRITE;
            default: begin
`ifdef TLB_MAINT_SWEEP_EN
              state_d = ST_SWEEP;
`else
              state_d = ST_DONE;
`endif
            end
          endcase
        end
      end

      ST_PROBE: begin
        s1_req = 1'b1;
        // A probe is the only command that can still be cancelled.
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          probe_found_d = bus.s1_found;
          probe_index_d = bus.s1_index;
          state_d       = ST_DONE;
        end
      end

      ST_READ: begin
        r_latch = 1'b1;
        state_d = ST_REFETCH;
      end

      ST_WRITE: begin
        we      = 1'b1;
        state_d = ST_REFETCH;
      end

      ST_SWEEP: begin
`ifdef TLB_MAINT_SWEEP_EN
        we      = 1'b1;
        w_clear = 1'b1;
        w_index = cnt;
        if (cnt_last) begin
          state_d = ST_REFETCH;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      ST_REFETCH: begin
        refetch_req = 1'b1;
        op_done     = 1'b1;
        state_d     = ST_IDLE;
      end

      ST_DONE: begin
        op_done = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      probe_found_q <= 1'b0;
      probe_index_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      probe_found_q <= probe_found_d;
      probe_index_q <= probe_index_d;
    end
  end

  assign bus.op_ready    = op_ready;
  assign bus.op_done     = op_done;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.s1_req      = s1_req;
  assign bus.probe_found = probe_found_q;
  assign bus.probe_index = probe_index_q;
  assign bus.we          = we;
  assign bus.w_index     = w_index;
  assign bus.w_clear     = w_clear;
  assign bus.r_index     = idx_q;
  assign bus.r_latch     = r_latch;
  assign bus.refetch_req = refetch_req;

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Randomized bench for tlb_maint_ctrl: each command's per-cycle output trace is
// derived from the command's timeline and compared cycle by cycle.
module tb_tlb_maint_ctrl;
  import tlb_maint_pkg::*;

  localparam int TLBNUM = 16;
  localparam int IDX_W  = 4;

`ifdef TLB_MAINT_SWEEP_EN
  localparam bit SWEEP_ON = 1'b1;
`else
  localparam bit SWEEP_ON = 1'b0;
`endif

  localparam logic [7:0] F_RDY  = 8'h80;
  localparam logic [7:0] F_DONE = 8'h40;
  localparam logic [7:0] F_BSY  = 8'h20;
  localparam logic [7:0] F_S1   = 8'h10;
  localparam logic [7:0] F_WE   = 8'h08;
  localparam logic [7:0] F_WCLR = 8'h04;
  localparam logic [7:0] F_RL   = 8'h02;
  localparam logic [7:0] F_RF   = 8'h01;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  tlb_maint_ctrl_if #(.IDX_W(IDX_W)) bus ();

  tlb_maint_ctrl #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  // reference model state: last accepted index and last completed probe result
  logic [IDX_W-1:0] idx_m = '0;
  logic             pf_m  = 1'b0;
  logic [IDX_W-1:0] pi_m  = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {11'd0, bus.op_ready, bus.op_done, bus.busy, bus.s1_req, bus.we, bus.w_clear,
            bus.r_latch, bus.refetch_req, bus.w_index, bus.r_index, bus.probe_found, bus.probe_index};
  endfunction

  function automatic logic [31:0] exp_vec(input logic [7:0] flags, input logic [IDX_W-1:0] widx);
    return {11'd0, flags, widx, idx_m, pf_m, pi_m};
  endfunction

  function automatic int cmd_len(input logic [1:0] code, input bit flushed);
    case (code)
      2'd0:    return flushed ? 1 : 2;
      2'd1:    return 2;
      2'd2:    return 2;
      default: return SWEEP_ON ? TLBNUM + 1 : 1;
    endcase
  endfunction

  // expected outputs k cycles after the accepting edge (k within the command)
  function automatic logic [31:0] exp_cycle(input logic [1:0] code, input int k);
    case (code)
      2'd0: return (k == 1) ? exp_vec(F_BSY | F_S1, idx_m) : exp_vec(F_BSY | F_DONE, idx_m);
      2'd1: return (k == 1) ? exp_vec(F_BSY | F_RL, idx_m) : exp_vec(F_BSY | F_DONE | F_RF, idx_m);
      2'd2: return (k == 1) ? exp_vec(F_BSY | F_WE, idx_m) : exp_vec(F_BSY | F_DONE | F_RF, idx_m);
      default: begin
        if (!SWEEP_ON) return exp_vec(F_BSY | F_DONE, idx_m);
        if (k <= TLBNUM) return exp_vec(F_BSY | F_WE | F_WCLR, IDX_W'(k - 1));
        return exp_vec(F_BSY | F_DONE | F_RF, idx_m);
      end
    endcase
  endfunction

  task automatic accept_cmd(input logic [1:0] code, input logic [IDX_W-1:0] idx);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.op_index = idx;
    bus.flush    = 1'b0;
    bus.s1_found = 1'($urandom);
    bus.s1_index = IDX_W'($urandom);
    #1;
    check_val($sformatf("accept op%0d", code), obs_vec(), exp_vec(F_RDY, idx_m));
    idx_m = idx;
  endtask

  task automatic run_cmd(input logic [1:0] code, input logic [IDX_W-1:0] idx,
                         input bit flush_probe, input logic s1f, input logic [IDX_W-1:0] s1i);
    bit flushed;
    bit flush_ok;
    int len;
    flushed  = (code == TLBOP_P) && flush_probe;
    flush_ok = (code == TLBOP_R) || (code == TLBOP_WI) || (code == TLBOP_INVALL && SWEEP_ON);
    len      = cmd_len(code, flushed);
    accept_cmd(code, idx);
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      bus.op_valid = (k <= len) ? 1'($urandom) : 1'b0;
      bus.op_code  = 2'($urandom);
      bus.op_index = IDX_W'($urandom);
      bus.s1_found = 1'($urandom);
      bus.s1_index = IDX_W'($urandom);
      if (code == TLBOP_P && k == 1) begin
        bus.s1_found = s1f;
        bus.s1_index = s1i;
        bus.flush    = flushed;
      end else begin
        bus.flush = (k <= len) && flush_ok && 1'($urandom);
      end
      #1;
      if (k > len) check_val($sformatf("idle after op%0d", code), obs_vec(), exp_vec(F_RDY, idx_m));
      else check_val($sformatf("op%0d cycle %0d", code, k), obs_vec(), exp_cycle(code, k));
      if (code == TLBOP_P && k == 1 && !flushed) begin
        pf_m = s1f;
        pi_m = s1i;
      end
    end
  endtask

  task automatic flush_idle();
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = 2'($urandom);
    bus.op_index = IDX_W'($urandom);
    bus.flush    = 1'b1;
    #1;
    check_val("flush blocks ready", obs_vec(), exp_vec(8'h00, idx_m));
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.flush    = 1'b0;
    #1;
    check_val("flush blocks accept", obs_vec(), exp_vec(F_RDY, idx_m));
  endtask

  task automatic reset_mid(input logic [1:0] code, input int ncyc);
    accept_cmd(code, IDX_W'($urandom));
    bus.op_valid = 1'b0;
    for (int k = 1; k < ncyc; k++) @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    idx_m = '0;
    pf_m  = 1'b0;
    pi_m  = '0;
    check_val("reset mid-command", obs_vec(), exp_vec(F_RDY, idx_m));
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    bus.op_valid = 1'b0;
    bus.op_code  = '0;
    bus.op_index = '0;
    bus.flush    = 1'b0;
    bus.s1_found = 1'b0;
    bus.s1_index = '0;
    repeat (2) @(negedge clk);
    #1;
    check_val("reset state", obs_vec(), exp_vec(F_RDY, idx_m));
    @(negedge clk);
    resetn = 1'b1;

    run_cmd(TLBOP_WI, 4'd5, 1'b0, 1'b0, 4'd0);
    run_cmd(TLBOP_P, 4'd1, 1'b0, 1'b1, 4'd9);
    run_cmd(TLBOP_P, 4'd2, 1'b1, 1'b0, 4'd4);
    run_cmd(TLBOP_INVALL, 4'd7, 1'b0, 1'b0, 4'd0);
    reset_mid(SWEEP_ON ? TLBOP_INVALL : TLBOP_WI, SWEEP_ON ? 7 : 1);
    run_cmd(TLBOP_R, 4'd3, 1'b0, 1'b0, 4'd0);
    run_cmd(TLBOP_INVALL, 4'd12, 1'b0, 1'b0, 4'd0);
    flush_idle();

    for (int n = 0; n < 60; n++) begin
      run_cmd(2'($urandom), IDX_W'($urandom), ($urandom_range(0, 3) == 0),
              1'($urandom), IDX_W'($urandom));
      if ($urandom_range(0, 7) == 0) flush_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
